// File: rtl/gyro_pkg.sv
// gyro_pkg: shared types and constants for the SPI gyroscope reader.
//   gyro_state_t   - transaction FSM states (IDLE, SETUP, SHIFT, HOLD)
//   GYRO_BITS      - SCLK cycles per burst (address byte + 6 data bytes)
//   GYRO_ADDR_BITS - width of the read/address byte
//   GYRO_RATE_W    - width of one raw angular-rate sample
//   GYRO_OUT_W     - width of each axis result
//   gyro_sext()    - sign-extend a raw rate to the result width
package gyro_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} gyro_state_t;

  localparam int unsigned GYRO_BITS      = 56;
  localparam int unsigned GYRO_ADDR_BITS = 8;
  localparam int unsigned GYRO_RATE_W    = 16;
  localparam int unsigned GYRO_OUT_W     = 32;
  localparam int unsigned GYRO_RX_BITS   = GYRO_BITS - GYRO_ADDR_BITS;

  function automatic logic [GYRO_OUT_W-1:0] gyro_sext(input logic [GYRO_RATE_W-1:0] r);
    return {{(GYRO_OUT_W - GYRO_RATE_W){r[GYRO_RATE_W-1]}}, r};
  endfunction

endpackage

// File: rtl/gyro_spi_reader_if.sv
// gyro_spi_reader_if: 4-wire SPI bus between the reader and the gyroscope.
//   cs_n - chip select, active low (master -> slave)
//   sclk - SPI clock, idles high, mode 3 (master -> slave)
//   mosi - master data out (master -> slave)
//   miso - slave data out (slave -> master)
interface gyro_spi_reader_if;
  logic cs_n;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output cs_n, output sclk, output mosi, input miso);
  modport slave  (input cs_n, input sclk, input mosi, output miso);
endinterface

// File: rtl/gyro_spi_reader_spi_shift_engine.sv
// spi_shift_engine: one SPI mode-3 burst of GYRO_BITS clocks per start.
//   clk, rst - system clock, synchronous active-high reset
//   start    - begin a burst (ignored unless idle)
//   miso     - raw SPI input, synchronised here
//   cs_n, sclk, mosi - registered SPI outputs
//   done     - one-cycle pulse on the edge that ends HOLD and raises cs_n
//   rx_word  - last GYRO_RX_BITS received bits, MSB first
module spi_shift_engine
  import gyro_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_SCLK = 4,
  parameter logic [6:0]  START_ADDR         = 7'h43
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    miso,
  output logic                    cs_n,
  output logic                    sclk,
  output logic                    mosi,
  output logic                    done,
  output logic [GYRO_RX_BITS-1:0] rx_word
);

  localparam int unsigned HW        = $clog2(CLKS_PER_HALF_SCLK);
  localparam int unsigned IW        = $clog2(2 * GYRO_BITS);
  localparam int unsigned LAST_HALF = 2 * GYRO_BITS - 1;
  localparam logic [HW-1:0] HALF_MAX = HW'(CLKS_PER_HALF_SCLK - 1);

  gyro_state_t          state, state_n;
  logic [HW-1:0]        hcnt;
  logic [IW-1:0]        half_idx;
  logic [GYRO_BITS-1:0] tx_sr;
  logic [1:0]           miso_sync;
  logic [1:0]           samp_dly;
  logic                 half_end, load, fall, rise;

  assign half_end = (hcnt == HALF_MAX);

  // SHIFT spans 56 full low+high SCLK periods; the high half of the last
  // period belongs to SHIFT, so HOLD adds one more half-period after it.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    fall    = 1'b0;
    rise    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE:  if (start) begin
               state_n = SETUP;
               load    = 1'b1;
             end
      SETUP: if (half_end) begin
               state_n = SHIFT;
               fall    = 1'b1;
             end
      SHIFT: if (half_end) begin
               if (half_idx == IW'(LAST_HALF)) state_n = HOLD;
               else if (sclk)                  fall    = 1'b1;
               else                            rise    = 1'b1;
             end
      HOLD:  if (half_end) begin
               state_n = IDLE;
               done    = 1'b1;
             end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hcnt      <= '0;
      half_idx  <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b1;
      mosi      <= 1'b0;
      tx_sr     <= '0;
      rx_word   <= '0;
      miso_sync <= '0;
      samp_dly  <= '0;
    end else begin
      state     <= state_n;
      miso_sync <= {miso_sync[0], miso};
      // Sample strobe trails the internal rising edge by the synchroniser depth.
      samp_dly  <= {samp_dly[0], rise};
      hcnt      <= (state == IDLE || half_end) ? '0 : hcnt + HW'(1);
      if (state != SHIFT)  half_idx <= '0;
      else if (half_end)   half_idx <= half_idx + IW'(1);

      if (load)      cs_n <= 1'b0;
      else if (done) cs_n <= 1'b1;

      if (fall)      sclk <= 1'b0;
      else if (rise) sclk <= 1'b1;

      if (load) begin
        tx_sr <= {1'b1, START_ADDR, {GYRO_RX_BITS{1'b0}}};
      end else if (fall) begin
        mosi  <= tx_sr[GYRO_BITS-1];
        tx_sr <= {tx_sr[GYRO_BITS-2:0], 1'b0};
      end

      // Address-byte samples simply fall off the top of the 48-bit register.
      if (samp_dly[1]) rx_word <= {rx_word[GYRO_RX_BITS-2:0], miso_sync[1]};
    end
  end

endmodule

// File: rtl/gyro_spi_reader.sv
// gyro_spi_reader: periodic 6-byte burst read of a gyroscope's X/Y/Z rates,
// delivering sign-extended or integrated 32-bit results.
//   clk, rst  - system clock, synchronous active-high reset
//   accum_en  - 1: integrate rates, 0: pass sign-extended raw rate
//   clear_i   - synchronous zero of gx/gy/gz (wins over an update)
//   spi       - SPI master bus (cs_n, sclk, mosi, miso)
//   gx/gy/gz  - axis results, two's complement
//   valid_o   - one-cycle pulse when gx/gy/gz update
module gyro_spi_reader
  import gyro_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_SCLK = 4,
  parameter int unsigned SAMPLE_PERIOD      = 100000,
  parameter logic [6:0]  START_ADDR         = 7'h43
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accum_en,
  input  logic                  clear_i,
  gyro_spi_reader_if.master     spi,
  output logic [GYRO_OUT_W-1:0] gx,
  output logic [GYRO_OUT_W-1:0] gy,
  output logic [GYRO_OUT_W-1:0] gz,
  output logic                  valid_o
);

  localparam logic [31:0] TICK_AT = 32'(SAMPLE_PERIOD - 1);

  logic [31:0]             timer;
  logic                    tick, done;
  logic                    cs_n, sclk, mosi;
  logic [GYRO_RX_BITS-1:0] rx_word;
  logic [GYRO_RATE_W-1:0]  rx, ry, rz;

  // Registered tick: first tick SAMPLE_PERIOD cycles after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (timer == TICK_AT);
      timer <= (timer == TICK_AT) ? '0 : timer + 32'd1;
    end
  end

  spi_shift_engine #(
    .CLKS_PER_HALF_SCLK (CLKS_PER_HALF_SCLK),
    .START_ADDR         (START_ADDR)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (tick),
    .miso    (spi.miso),
    .cs_n    (cs_n),
    .sclk    (sclk),
    .mosi    (mosi),
    .done    (done),
    .rx_word (rx_word)
  );

  assign spi.cs_n = cs_n;
  assign spi.sclk = sclk;
  assign spi.mosi = mosi;

  assign rx = rx_word[47:32];
  assign ry = rx_word[31:16];
  assign rz = rx_word[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      gx      <= '0;
      gy      <= '0;
      gz      <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= done;
      if (clear_i) begin
        gx <= '0;
        gy <= '0;
        gz <= '0;
      end else if (done) begin
        if (accum_en) begin
          gx <= gx + gyro_sext(rx);
          gy <= gy + gyro_sext(ry);
          gz <= gz + gyro_sext(rz);
        end else begin
          gx <= gyro_sext(rx);
          gy <= gyro_sext(ry);
          gz <= gyro_sext(rz);
        end
      end
    end
  end

endmodule

// File: doc/gyro_spi_reader.md
# gyro_spi_reader

Periodically reads the three signed 16-bit angular-rate registers of an SPI gyroscope (MPU-9250 class, mode 3) in one 6-byte burst. It sign-extends each rate to 32 bits, or integrates it into a 32-bit running sum. The block sits directly upstream of the debug I/O core and drives its `gx`/`gy`/`gz` probe inputs, which are sampled by the host over UART.

## Interface
- `CLKS_PER_HALF_SCLK`, default 4: `clk` cycles per SCLK half-period; must be ≥2.
- `SAMPLE_PERIOD`, default 100000: `clk` cycles between transaction starts (1 kHz at 100 MHz).
- `START_ADDR`, default 7'h43: 7-bit register address of GYRO_XOUT_H.

Ports:
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `accum_en` input 1: 1 means integrate rates; 0 means pass the sign-extended raw rate.
- `clear_i` input 1: synchronous zero of `gx`/`gy`/`gz`.
- `cs_n` output 1: SPI chip select, active low.
- `sclk` output 1: SPI clock, idles high.
- `mosi` output 1: SPI data out.
- `miso` input 1: SPI data in; double-flopped internally.
- `gx`, `gy`, `gz` output 32 each: axis results, two's complement.
- `valid_o` output 1: one-cycle pulse when `gx`/`gy`/`gz` update.

## Operation
- The sample timer counts 0..`SAMPLE_PERIOD`-1 and wraps. Wrap asserts an internal tick.
- A tick in IDLE starts a transaction. A tick in any other state is dropped; there is no queue.
- FSM states:
  - IDLE: `cs_n`=1, `sclk`=1.
  - SETUP: `cs_n`=0 for one half-period.
  - SHIFT: 56 SCLK cycles.
  - HOLD: one half-period with `cs_n` still 0.
  - Back to IDLE, raising `cs_n`.
- SHIFT bit order is MSB first:
  - Bits 0–7 of `mosi` are {1'b1, `START_ADDR`}, the read bit plus address.
  - `mosi` is 0 for bits 8–55.
  - `mosi` changes on the SCLK falling edge. `miso` is sampled on the rising edge into a 48-bit shift register; the address-byte samples are discarded.
- Received bytes are XH, XL, YH, YL, ZH, ZL. The raw rates are rx={XH,XL}, ry, rz, each signed 16-bit.
- Update on leaving HOLD:
  - `accum_en`=0: `gx` = {{16{rx[15]}}, rx}, and likewise for y and z.
  - `accum_en`=1: `gx` = `gx` + sext(rx), modulo 2^32 with silent wrap, and likewise for y and z.
  - `valid_o` pulses for the same cycle.
- `clear_i` zeroes all three outputs on the next edge. If it coincides with an update, clear wins: outputs become 0, the sample is discarded, and `valid_o` still pulses.
- `accum_en` is sampled only at the update edge.

## Timing
- Reset values: `cs_n`=1, `sclk`=1, `mosi`=0, `gx`=`gy`=`gz`=0, `valid_o`=0, FSM=IDLE, timer=0, shift registers=0.
- `rst` mid-transaction aborts it. On the next edge `cs_n`=1 and `sclk`=1, and the outputs are zeroed.
- First tick arrives `SAMPLE_PERIOD` cycles after `rst` deasserts. `cs_n` falls on the edge after the tick.
- SCLK period is 2·`CLKS_PER_HALF_SCLK`. The first falling edge occurs `CLKS_PER_HALF_SCLK` cycles after `cs_n` falls.
- The last rising edge is followed by `CLKS_PER_HALF_SCLK` cycles of hold. Then `cs_n` rises in the same cycle that outputs update and `valid_o`=1.
- Transaction length from `cs_n` low to high is 2·`CLKS_PER_HALF_SCLK`·57 cycles, which is 456 at the default. `SAMPLE_PERIOD` must exceed this; otherwise every other tick is dropped.
- `miso` synchronizer adds 2 cycles. The sample point is delayed accordingly, so the effective sample lands 2 cycles after the internal rising edge; `CLKS_PER_HALF_SCLK` ≥ 3 is required for margin.

## Structure
- Package `gyro_pkg` holds:
  - the FSM state enum (IDLE, SETUP, SHIFT, HOLD);
  - `GYRO_BITS`=56;
  - `GYRO_ADDR_BITS`=8;
  - `GYRO_RATE_W`=16;
  - `GYRO_OUT_W`=32.
- Sub-module `spi_shift_engine` contains the SCLK divider, bit counter, and MOSI/MISO shift registers, with start/done handshake. It asserts a done pulse after HOLD and exposes the 48-bit receive word.
- The top level holds the sample timer, sign-extension/accumulate datapath, and clear logic.

## Test plan
- Address byte: slave model captures `mosi` on rising edges → first byte 8'hC3, then 48 zeros. Check `cs_n` low duration = 456 cycles and SCLK period = 8 cycles.
- Raw mode: slave returns 01 02 FF FE 80 00 with `accum_en`=0 → `gx`=32'h00000102, `gy`=32'hFFFFFFFE, `gz`=32'hFFFF8000, with `valid_o` high exactly one cycle.
- Accumulate: x=16'h0102 and y=16'hFFFE for 3 samples with `accum_en`=1 → `gx`=32'h00000306, `gy`=32'hFFFFFFFA after the third `valid_o`.
- Clear collision: assert `clear_i` on the update cycle → `gx`=`gy`=`gz`=0 and `valid_o` pulses. The next sample with x=1 gives `gx`=1.
- Reset mid-SHIFT: assert `rst` at bit 20 → next edge `cs_n`=1, `sclk`=1, outputs 0. A full clean transaction follows `SAMPLE_PERIOD` cycles after release.
- Overrun: `SAMPLE_PERIOD`=300 (less than 456) → transactions start every 600 cycles and none overlap.
